// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_pkg
// Description : Shared vector-unit types, widths and osize helper functions
//               used by the extension sequencer and the extend datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH       = 128;
  localparam int RISCV_V_NUM_BYTES_DATA   = RISCV_V_DATA_WIDTH / 8;
  localparam int RISCV_V_NUM_VALID_OSIZES = 5;   // 8/16/32/64/128 b
  localparam int RISCV_V_OSIZE_IDX_W      = 3;   // index of a one-hot osize bit
  localparam int RISCV_V_UOP_IDX_W        = 4;   // up to 16 micro-ops (8 -> 128 b)

  // Source operand packing shared with riscv_v_extend: {data, byte_a, byte_b}
  typedef struct packed {
    logic [RISCV_V_DATA_WIDTH-1:0]     data;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_a;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_b;
  } riscv_v_src_t;

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } riscv_v_seq_state_e;

  // Position of the set bit; the highest set bit wins if several are set.
  function automatic logic [RISCV_V_OSIZE_IDX_W-1:0] onehot_to_idx(
    input logic [RISCV_V_NUM_VALID_OSIZES-1:0] oh
  );
    logic [RISCV_V_OSIZE_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++) begin
      if (oh[i]) idx = RISCV_V_OSIZE_IDX_W'(i);
    end
    return idx;
  endfunction

  // True when exactly one osize bit is set.
  function automatic logic is_onehot(
    input logic [RISCV_V_NUM_VALID_OSIZES-1:0] oh
  );
    logic [RISCV_V_OSIZE_IDX_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++) begin
      cnt = cnt + RISCV_V_OSIZE_IDX_W'(oh[i]);
    end
    return (cnt == RISCV_V_OSIZE_IDX_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_v_ext_slice_shift.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_ext_slice_shift
// Description : Combinational byte-granular barrel shifter that moves the
//               uop_idx-th 1/R slice of a source operand (data plus both byte
//               fields) down to byte 0, zero-filling from the top.
//               R = 1 << shift_log; byte shift = (uop_idx * NUM_BYTES) >> shift_log.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_v_ext_slice_shift
  import riscv_v_pkg::*;
#(
  parameter int DATA_W      = RISCV_V_DATA_WIDTH,
  parameter int NUM_BYTES   = DATA_W / 8,
  parameter int SHIFT_LOG_W = RISCV_V_OSIZE_IDX_W,
  parameter int UOP_IDX_W   = RISCV_V_UOP_IDX_W
) (
  input  logic [SHIFT_LOG_W-1:0] shift_log,
  input  logic [UOP_IDX_W-1:0]   uop_idx,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [NUM_BYTES-1:0]   in_byte_a,
  input  logic [NUM_BYTES-1:0]   in_byte_b,
  output logic [DATA_W-1:0]      out_data,
  output logic [NUM_BYTES-1:0]   out_byte_a,
  output logic [NUM_BYTES-1:0]   out_byte_b
);

  localparam int BYTE_IDX_W = $clog2(NUM_BYTES);
  localparam int CNT_W      = BYTE_IDX_W + UOP_IDX_W;

  logic [CNT_W-1:0]     w_byte_offset;
  logic [CNT_W-1:0]     w_byte_cnt;
  logic [DATA_W-1:0]    w_data_stg   [CNT_W+1];
  logic [NUM_BYTES-1:0] w_byte_a_stg [CNT_W+1];
  logic [NUM_BYTES-1:0] w_byte_b_stg [CNT_W+1];

  // Offset of slice uop_idx in bytes: uop_idx * (NUM_BYTES / R)
  assign w_byte_offset = CNT_W'(uop_idx) * CNT_W'(NUM_BYTES);
  assign w_byte_cnt    = w_byte_offset >> shift_log;

  assign w_data_stg[0]   = in_data;
  assign w_byte_a_stg[0] = in_byte_a;
  assign w_byte_b_stg[0] = in_byte_b;

  // One log stage per shift-count bit; stages at or beyond the operand width
  // can only empty the operand.
  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    if ((2 ** i) < NUM_BYTES) begin : g_shift
      assign w_data_stg[i+1]   = w_byte_cnt[i] ? (w_data_stg[i] >> (8 * (2 ** i)))
                                               : w_data_stg[i];
      assign w_byte_a_stg[i+1] = w_byte_cnt[i] ? (w_byte_a_stg[i] >> (2 ** i))
                                               : w_byte_a_stg[i];
      assign w_byte_b_stg[i+1] = w_byte_cnt[i] ? (w_byte_b_stg[i] >> (2 ** i))
                                               : w_byte_b_stg[i];
    end else begin : g_clear
      assign w_data_stg[i+1]   = w_byte_cnt[i] ? '0 : w_data_stg[i];
      assign w_byte_a_stg[i+1] = w_byte_cnt[i] ? '0 : w_byte_a_stg[i];
      assign w_byte_b_stg[i+1] = w_byte_cnt[i] ? '0 : w_byte_b_stg[i];
    end
  end

  assign out_data   = w_data_stg[CNT_W];
  assign out_byte_a = w_byte_a_stg[CNT_W];
  assign out_byte_b = w_byte_b_stg[CNT_W];

endmodule
`default_nettype wire

// File: rtl/riscv_v_ext_src_seq.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_ext_src_seq
// Description : Micro-op sequencer for vzext/vsext .vf2/.vf4/.vf8/.vf16.
//               Registers one source operand per instruction and issues
//               R = 2^(dst_idx - src_idx) micro-ops, each carrying the next
//               1/R source slice at byte 0 and destination register vd + k.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_v_ext_src_seq
  import riscv_v_pkg::*;
#(
  parameter int DATA_W     = RISCV_V_DATA_WIDTH,
  parameter int NUM_BYTES  = DATA_W / 8,
  parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES,
  parameter int VREG_IDX_W = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  // instruction input
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W+2*NUM_BYTES-1:0]   in_src,
  input  logic [NUM_OSIZES-1:0]           in_src_osize,
  input  logic [NUM_OSIZES-1:0]           in_dst_osize,
  input  logic                            in_is_zero_ext,
  input  logic                            in_is_sign_ext,
  input  logic [VREG_IDX_W-1:0]           in_vd,
  // micro-op output
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W+2*NUM_BYTES-1:0]   out_src,
  output logic [NUM_OSIZES-1:0]           out_src_osize,
  output logic [NUM_OSIZES-1:0]           out_dst_osize,
  output logic                            out_is_zero_ext,
  output logic                            out_is_sign_ext,
  output logic [VREG_IDX_W-1:0]           out_vd,
  output logic [3:0]                      out_uop_idx,
  output logic                            out_last,
  output logic                            out_err
);

  localparam int SRC_W  = DATA_W + 2 * NUM_BYTES;
  localparam int UOP_W  = RISCV_V_UOP_IDX_W;
  localparam int SLOG_W = RISCV_V_OSIZE_IDX_W;

  // --------------------------------------------------------------------------
  // State and payload registers
  // --------------------------------------------------------------------------
  riscv_v_seq_state_e      state_q, state_d;
  logic [UOP_W-1:0]        uop_cnt_q, uop_cnt_d;
  logic [SLOG_W-1:0]       shift_log_q, shift_log_d;
  logic                    err_q, err_d;
  logic [SRC_W-1:0]        src_q, src_d;
  logic [NUM_OSIZES-1:0]   src_osize_q, src_osize_d;
  logic [NUM_OSIZES-1:0]   dst_osize_q, dst_osize_d;
  logic                    zext_q, zext_d;
  logic                    sext_q, sext_d;
  logic [VREG_IDX_W-1:0]   vd_q, vd_d;

  // --------------------------------------------------------------------------
  // Decode of the incoming osizes
  // --------------------------------------------------------------------------
  logic [SLOG_W-1:0]       w_src_idx;
  logic [SLOG_W-1:0]       w_dst_idx;
  logic                    w_is_ext;
  logic                    w_bad_osize;
  logic [SLOG_W-1:0]       w_in_shift_log;
  logic                    w_in_err;

  assign w_src_idx   = onehot_to_idx(in_src_osize);
  assign w_dst_idx   = onehot_to_idx(in_dst_osize);
  assign w_is_ext    = in_is_zero_ext || in_is_sign_ext;
  assign w_bad_osize = !is_onehot(in_src_osize) || !is_onehot(in_dst_osize)
                    || (w_dst_idx <= w_src_idx);

  // Illegal extensions and plain pass-through both collapse to a single micro-op.
  assign w_in_err       = w_is_ext && w_bad_osize;
  assign w_in_shift_log = (w_is_ext && !w_bad_osize) ? (w_dst_idx - w_src_idx) : '0;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic [UOP_W:0]          w_uop_total;
  logic [UOP_W-1:0]        w_last_idx;
  logic                    w_is_last;
  logic                    w_out_fire;
  logic                    w_accept;

  assign w_uop_total = (UOP_W + 1)'(1) << shift_log_q;
  assign w_last_idx  = UOP_W'(w_uop_total - (UOP_W + 1)'(1));
  assign w_is_last   = (uop_cnt_q == w_last_idx);

  assign out_valid   = (state_q == SEQ_ISSUE);
  assign w_out_fire  = out_valid && out_ready;
  // A new instruction may load in the same cycle the final micro-op leaves.
  assign in_ready    = !flush && ((state_q == SEQ_IDLE) || (w_out_fire && w_is_last));
  assign w_accept    = in_valid && in_ready;

  // Next-state, micro-op counter and payload capture
  always_comb begin
    state_d     = state_q;
    uop_cnt_d   = uop_cnt_q;
    shift_log_d = shift_log_q;
    err_d       = err_q;
    src_d       = src_q;
    src_osize_d = src_osize_q;
    dst_osize_d = dst_osize_q;
    zext_d      = zext_q;
    sext_d      = sext_q;
    vd_d        = vd_q;

    if (w_accept) begin
      state_d     = SEQ_ISSUE;
      uop_cnt_d   = '0;
      shift_log_d = w_in_shift_log;
      err_d       = w_in_err;
      src_d       = in_src;
      src_osize_d = in_src_osize;
      dst_osize_d = in_dst_osize;
      zext_d      = in_is_zero_ext;
      sext_d      = in_is_sign_ext;
      vd_d        = in_vd;
    end else if (w_out_fire) begin
      if (w_is_last) begin
        state_d   = SEQ_IDLE;
        uop_cnt_d = '0;
      end else begin
        uop_cnt_d = uop_cnt_q + UOP_W'(1);
      end
    end

    // Flush wins over everything; in_ready is already low so nothing loads.
    if (flush) begin
      state_d   = SEQ_IDLE;
      uop_cnt_d = '0;
    end
  end

  // State and payload registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      uop_cnt_q   <= '0;
      shift_log_q <= '0;
      err_q       <= 1'b0;
      src_q       <= '0;
      src_osize_q <= '0;
      dst_osize_q <= '0;
      zext_q      <= 1'b0;
      sext_q      <= 1'b0;
      vd_q        <= '0;
    end else begin
      state_q     <= state_d;
      uop_cnt_q   <= uop_cnt_d;
      shift_log_q <= shift_log_d;
      err_q       <= err_d;
      src_q       <= src_d;
      src_osize_q <= src_osize_d;
      dst_osize_q <= dst_osize_d;
      zext_q      <= zext_d;
      sext_q      <= sext_d;
      vd_q        <= vd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Slice selection
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]    w_slice_data;
  logic [NUM_BYTES-1:0] w_slice_byte_a;
  logic [NUM_BYTES-1:0] w_slice_byte_b;

  riscv_v_ext_slice_shift #(
    .DATA_W      (DATA_W),
    .NUM_BYTES   (NUM_BYTES),
    .SHIFT_LOG_W (SLOG_W),
    .UOP_IDX_W   (UOP_W)
  ) u_slice_shift (
    .shift_log  (shift_log_q),
    .uop_idx    (uop_cnt_q),
    .in_data    (src_q[SRC_W-1 -: DATA_W]),
    .in_byte_a  (src_q[2*NUM_BYTES-1 -: NUM_BYTES]),
    .in_byte_b  (src_q[NUM_BYTES-1:0]),
    .out_data   (w_slice_data),
    .out_byte_a (w_slice_byte_a),
    .out_byte_b (w_slice_byte_b)
  );

  // --------------------------------------------------------------------------
  // Outputs: all derived from registers, so stable under backpressure
  // --------------------------------------------------------------------------
  assign out_src         = {w_slice_data, w_slice_byte_a, w_slice_byte_b};
  assign out_src_osize   = src_osize_q;
  assign out_dst_osize   = dst_osize_q;
  assign out_is_zero_ext = zext_q;
  assign out_is_sign_ext = sext_q;
  assign out_vd          = vd_q + VREG_IDX_W'(uop_cnt_q);   // wraps mod 2^VREG_IDX_W
  assign out_uop_idx     = uop_cnt_q;
  assign out_last        = out_valid && w_is_last;
  assign out_err         = out_valid && err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_ext_src_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_v_ext_src_seq
// Description : Directed self-checking bench for the extension micro-op
//               sequencer: vf2/vf4/vf8/vf16 slicing, backpressure,
//               back-to-back issue, flush, illegal osizes and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_v_ext_src_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [159:0] in_src = '0;
  logic [4:0]   in_src_osize = '0;
  logic [4:0]   in_dst_osize = '0;
  logic         in_is_zero_ext = 1'b0;
  logic         in_is_sign_ext = 1'b0;
  logic [4:0]   in_vd = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [159:0] out_src;
  logic [4:0]   out_src_osize;
  logic [4:0]   out_dst_osize;
  logic         out_is_zero_ext;
  logic         out_is_sign_ext;
  logic [4:0]   out_vd;
  logic [3:0]   out_uop_idx;
  logic         out_last;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  riscv_v_ext_src_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_src          (in_src),
    .in_src_osize    (in_src_osize),
    .in_dst_osize    (in_dst_osize),
    .in_is_zero_ext  (in_is_zero_ext),
    .in_is_sign_ext  (in_is_sign_ext),
    .in_vd           (in_vd),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_src         (out_src),
    .out_src_osize   (out_src_osize),
    .out_dst_osize   (out_dst_osize),
    .out_is_zero_ext (out_is_zero_ext),
    .out_is_sign_ext (out_is_sign_ext),
    .out_vd          (out_vd),
    .out_uop_idx     (out_uop_idx),
    .out_last        (out_last),
    .out_err         (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_uop(input string tag, input logic [3:0] k, input logic [4:0] vd,
                         input logic last, input logic [159:0] src);
    chk({tag, " valid"},   {159'b0, out_valid}, 160'd1);
    chk({tag, " uop_idx"}, {156'b0, out_uop_idx}, {156'b0, k});
    chk({tag, " vd"},      {155'b0, out_vd}, {155'b0, vd});
    chk({tag, " last"},    {159'b0, out_last}, {159'b0, last});
    chk({tag, " src"},     out_src, src);
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] d, input logic [15:0] ba, input logic [15:0] bb,
                      input logic [4:0] so, input logic [4:0] dso,
                      input logic z, input logic s, input logic [4:0] vd);
    in_src         = {d, ba, bb};
    in_src_osize   = so;
    in_dst_osize   = dso;
    in_is_zero_ext = z;
    in_is_sign_ext = s;
    in_vd          = vd;
    in_valid       = 1'b1;
  endtask

  logic [127:0] d_a;
  logic [127:0] d_16;
  logic [127:0] d_4;
  logic [15:0]  ba;
  logic [15:0]  bb;

  initial begin
    d_a  = 128'h8001_7FFF_0000_FFFF_1234_5678_9ABC_DEF0;
    d_16 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    d_4  = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    // ---------------- reset ----------------
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst out_valid", {159'b0, out_valid}, 160'd0);
    chk("rst in_ready",  {159'b0, in_ready},  160'd1);
    chk("rst out_src",   out_src, 160'd0);
    chk("rst out_vd",    {155'b0, out_vd}, 160'd0);
    chk("rst out_uop",   {156'b0, out_uop_idx}, 160'd0);
    chk("rst out_last",  {159'b0, out_last}, 160'd0);
    chk("rst out_err",   {159'b0, out_err}, 160'd0);

    // ---------------- vsext.vf2 16->32 ----------------
    load(d_a, 16'hA5C3, 16'h0FF0, 5'b00010, 5'b00100, 1'b0, 1'b1, 5'd8);
    #1;
    chk("vf2 in_ready idle", {159'b0, in_ready}, 160'd1);
    tick();
    in_valid = 1'b0;
    chk_uop("vf2 k0", 4'd0, 5'd8, 1'b0, {d_a, 16'hA5C3, 16'h0FF0});
    chk("vf2 dst_osize", {155'b0, out_dst_osize}, {155'b0, 5'b00100});
    chk("vf2 src_osize", {155'b0, out_src_osize}, {155'b0, 5'b00010});
    chk("vf2 sext",      {159'b0, out_is_sign_ext}, 160'd1);
    chk("vf2 zext",      {159'b0, out_is_zero_ext}, 160'd0);
    chk("vf2 err",       {159'b0, out_err}, 160'd0);
    chk("vf2 k0 in_ready", {159'b0, in_ready}, 160'd0);
    tick();
    chk_uop("vf2 k1", 4'd1, 5'd9, 1'b1,
            {128'h0000_0000_0000_0000_8001_7FFF_0000_FFFF, 16'h00A5, 16'h000F});
    chk("vf2 k1 in_ready", {159'b0, in_ready}, 160'd1);
    tick();
    chk("vf2 done valid", {159'b0, out_valid}, 160'd0);

    // ---------------- vzext.vf16 8->128, vd=30 ----------------
    ba = 16'hFFFF;
    bb = 16'h8001;
    load(d_16, ba, bb, 5'b00001, 5'b10000, 1'b1, 1'b0, 5'd30);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_uop($sformatf("vf16 k%0d", k), 4'(k), 5'(30 + k), (k == 15),
              {d_16 >> (8 * k), ba >> k, bb >> k});
      chk($sformatf("vf16 byte0 k%0d", k), {152'b0, out_src[39:32]}, 160'(k));
      tick();
    end
    chk("vf16 done valid", {159'b0, out_valid}, 160'd0);

    // ---------------- backpressure on vf4 8->32 ----------------
    ba = 16'hF00F;
    bb = 16'h1234;
    load(d_4, ba, bb, 5'b00001, 5'b00100, 1'b1, 1'b0, 5'd4);
    tick();
    in_valid = 1'b0;
    chk_uop("bp k0", 4'd0, 5'd4, 1'b0, {d_4, ba, bb});
    tick();
    chk_uop("bp k1", 4'd1, 5'd5, 1'b0, {d_4 >> 32, 16'h0F00, 16'h0123});
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_uop($sformatf("bp hold%0d", c), 4'd1, 5'd5, 1'b0,
              {128'h00000000_00112233_44556677_8899AABB, 16'h0F00, 16'h0123});
      chk($sformatf("bp hold%0d in_ready", c), {159'b0, in_ready}, 160'd0);
    end
    out_ready = 1'b1;
    tick();
    chk_uop("bp k2", 4'd2, 5'd6, 1'b0,
            {128'h00000000_00000000_00112233_44556677, 16'h00F0, 16'h0012});
    tick();
    chk_uop("bp k3", 4'd3, 5'd7, 1'b1,
            {128'h00000000_00000000_00000000_00112233, 16'h000F, 16'h0001});
    tick();
    chk("bp done valid", {159'b0, out_valid}, 160'd0);

    // ---------------- back-to-back vf2 then vf4 ----------------
    load(d_a, 16'h0000, 16'h0000, 5'b00010, 5'b00100, 1'b0, 1'b1, 5'd2);
    tick();
    load(d_4, 16'hF00F, 16'h1234, 5'b00001, 5'b00100, 1'b1, 1'b0, 5'd20);
    chk_uop("b2b A k0", 4'd0, 5'd2, 1'b0, {d_a, 32'h0});
    tick();
    chk_uop("b2b A k1", 4'd1, 5'd3, 1'b1, {d_a >> 64, 32'h0});
    chk("b2b A k1 in_ready", {159'b0, in_ready}, 160'd1);
    tick();
    in_valid = 1'b0;
    chk_uop("b2b B k0", 4'd0, 5'd20, 1'b0, {d_4, 16'hF00F, 16'h1234});
    chk("b2b B zext", {159'b0, out_is_zero_ext}, 160'd1);
    tick();
    chk_uop("b2b B k1", 4'd1, 5'd21, 1'b0, {d_4 >> 32, 16'h0F00, 16'h0123});
    tick();
    chk_uop("b2b B k2", 4'd2, 5'd22, 1'b0, {d_4 >> 64, 16'h00F0, 16'h0012});
    tick();
    chk_uop("b2b B k3", 4'd3, 5'd23, 1'b1, {d_4 >> 96, 16'h000F, 16'h0001});
    tick();
    chk("b2b done valid", {159'b0, out_valid}, 160'd0);

    // ---------------- flush during micro-op 2 of vf8 ----------------
    load(d_16, 16'hFFFF, 16'h0000, 5'b00001, 5'b01000, 1'b1, 1'b0, 5'd10);
    tick();
    in_valid = 1'b0;
    chk_uop("fl k0", 4'd0, 5'd10, 1'b0, {d_16, 16'hFFFF, 16'h0000});
    tick();
    tick();
    chk_uop("fl k2", 4'd2, 5'd12, 1'b0, {d_16 >> 32, 16'h0FFF, 16'h0000});
    flush = 1'b1;
    load(d_a, 16'hA5C3, 16'h0FF0, 5'b00010, 5'b00100, 1'b0, 1'b1, 5'd5);
    #1;
    chk("fl in_ready during flush", {159'b0, in_ready}, 160'd0);
    tick();
    chk("fl out_valid", {159'b0, out_valid}, 160'd0);
    chk("fl out_last",  {159'b0, out_last}, 160'd0);
    flush = 1'b0;
    #1;
    chk("fl in_ready after", {159'b0, in_ready}, 160'd1);
    tick();
    in_valid = 1'b0;
    chk_uop("fl new k0", 4'd0, 5'd5, 1'b0, {d_a, 16'hA5C3, 16'h0FF0});
    tick();
    chk_uop("fl new k1", 4'd1, 5'd6, 1'b1,
            {128'h0000_0000_0000_0000_8001_7FFF_0000_FFFF, 16'h00A5, 16'h000F});
    tick();
    chk("fl done valid", {159'b0, out_valid}, 160'd0);

    // ---------------- illegal dst == src == 32b with sign_ext ----------------
    load(d_a, 16'h3C3C, 16'h00FF, 5'b00100, 5'b00100, 1'b0, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    chk_uop("ill k0", 4'd0, 5'd7, 1'b1, {d_a, 16'h3C3C, 16'h00FF});
    chk("ill err", {159'b0, out_err}, 160'd1);
    tick();
    chk("ill done valid", {159'b0, out_valid}, 160'd0);
    chk("ill done err",   {159'b0, out_err}, 160'd0);

    // ---------------- pass-through (no ext flag) ----------------
    load(d_4, 16'h1111, 16'h2222, 5'b00001, 5'b00100, 1'b0, 1'b0, 5'd31);
    tick();
    in_valid = 1'b0;
    chk_uop("pt k0", 4'd0, 5'd31, 1'b1, {d_4, 16'h1111, 16'h2222});
    chk("pt err", {159'b0, out_err}, 160'd0);
    tick();

    // ---------------- reset mid-vf16 ----------------
    load(d_16, 16'hFFFF, 16'h8001, 5'b00001, 5'b10000, 1'b1, 1'b0, 5'd30);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rm uop_idx before", {156'b0, out_uop_idx}, 160'd3);
    rst_n = 1'b0;
    tick();
    chk("rm out_valid", {159'b0, out_valid}, 160'd0);
    chk("rm out_src",   out_src, 160'd0);
    chk("rm out_vd",    {155'b0, out_vd}, 160'd0);
    chk("rm out_uop",   {156'b0, out_uop_idx}, 160'd0);
    chk("rm out_last",  {159'b0, out_last}, 160'd0);
    chk("rm out_err",   {159'b0, out_err}, 160'd0);
    chk("rm dst_osize", {155'b0, out_dst_osize}, 160'd0);
    chk("rm zext",      {159'b0, out_is_zero_ext}, 160'd0);
    rst_n = 1'b1;
    tick();
    chk("rm after valid",    {159'b0, out_valid}, 160'd0);
    chk("rm after in_ready", {159'b0, in_ready}, 160'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
